// File: rtl/light_renderer.sv
// Renders the player square and two light streaks into RGB444 pixels and
// flags frames in which the player touches either light.
module light_renderer #(
  parameter logic [11:0] COL_PLAYER = 12'hFFF,
  parameter logic [11:0] COL_LIGHT1 = 12'h0FF,
  parameter logic [11:0] COL_LIGHT2 = 12'hF0F,
  parameter logic [11:0] COL_BG     = 12'h000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_frame_stb,
  input  logic        i_active,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic [11:0] i_px1,
  input  logic [11:0] i_px2,
  input  logic [11:0] i_py1,
  input  logic [11:0] i_py2,
  input  logic [11:0] i_1x1,
  input  logic [11:0] i_1x2,
  input  logic [11:0] i_1y1,
  input  logic [11:0] i_1y2,
  input  logic [11:0] i_2x1,
  input  logic [11:0] i_2x2,
  input  logic [11:0] i_2y1,
  input  logic [11:0] i_2y2,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_collide,
  output logic [7:0]  o_collide_cnt
);

  typedef struct packed {
    logic [11:0] px1, px2, py1, py2;
    logic [11:0] l1x1, l1x2, l1y1, l1y2;
    logic [11:0] l2x1, l2x2, l2y1, l2y2;
  } rects_t;

  rects_t      shadow_q, shadow_d;
  logic        s1_act_q, s1_act_d;
  logic        s1_hp_q, s1_hp_d;
  logic        s1_h1_q, s1_h1_d;
  logic        s1_h2_q, s1_h2_d;
  logic [11:0] col_q, col_d;
  logic        sticky_q, sticky_d;
  logic        collide_q, collide_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [11:0] x_ext, y_ext;
  logic        hit_p, hit_1, hit_2, coll_now;

  // Inverted or wrapped edges fall out naturally as empty rectangles.
  function automatic logic in_rect(input logic [11:0] x, input logic [11:0] y,
                                   input logic [11:0] x1, input logic [11:0] x2,
                                   input logic [11:0] y1, input logic [11:0] y2);
    return (x1 <= x) && (x < x2) && (y1 <= y) && (y < y2);
  endfunction

  always_comb begin
    x_ext    = {2'b00, i_x};
    y_ext    = {2'b00, i_y};
    hit_p    = in_rect(x_ext, y_ext, shadow_q.px1, shadow_q.px2, shadow_q.py1, shadow_q.py2);
    hit_1    = in_rect(x_ext, y_ext, shadow_q.l1x1, shadow_q.l1x2, shadow_q.l1y1, shadow_q.l1y2);
    hit_2    = in_rect(x_ext, y_ext, shadow_q.l2x1, shadow_q.l2x2, shadow_q.l2y1, shadow_q.l2y2);
    coll_now = i_pix_stb && i_active && hit_p && (hit_1 || hit_2);

    shadow_d  = shadow_q;
    s1_act_d  = s1_act_q;
    s1_hp_d   = s1_hp_q;
    s1_h1_d   = s1_h1_q;
    s1_h2_d   = s1_h2_q;
    col_d     = col_q;
    sticky_d  = sticky_q | coll_now;
    collide_d = collide_q;
    cnt_d     = cnt_q;

    if (i_pix_stb) begin
      s1_act_d = i_active;
      s1_hp_d  = hit_p;
      s1_h1_d  = hit_1;
      s1_h2_d  = hit_2;
      if (!s1_act_q)    col_d = 12'h000;
      else if (s1_hp_q) col_d = COL_PLAYER;
      else if (s1_h1_q) col_d = COL_LIGHT1;
      else if (s1_h2_q) col_d = COL_LIGHT2;
      else              col_d = COL_BG;
    end

    // A pixel entering stage 1 on the boundary belongs to the frame that ends.
    if (i_frame_stb) begin
      shadow_d  = '{i_px1, i_px2, i_py1, i_py2,
                    i_1x1, i_1x2, i_1y1, i_1y2,
                    i_2x1, i_2x2, i_2y1, i_2y2};
      collide_d = sticky_q | coll_now;
      sticky_d  = 1'b0;
      if (collide_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shadow_q  <= '0;
      s1_act_q  <= 1'b0;
      s1_hp_q   <= 1'b0;
      s1_h1_q   <= 1'b0;
      s1_h2_q   <= 1'b0;
      col_q     <= 12'h000;
      sticky_q  <= 1'b0;
      collide_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      shadow_q  <= shadow_d;
      s1_act_q  <= s1_act_d;
      s1_hp_q   <= s1_hp_d;
      s1_h1_q   <= s1_h1_d;
      s1_h2_q   <= s1_h2_d;
      col_q     <= col_d;
      sticky_q  <= sticky_d;
      collide_q <= collide_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_r           = col_q[11:8];
  assign o_g           = col_q[7:4];
  assign o_b           = col_q[3:0];
  assign o_collide     = collide_q;
  assign o_collide_cnt = cnt_q;

endmodule
